// File: rtl/uart_tx_ctrl.sv
// Buffered 8N1 UART transmitter: a FIFO of queued bytes feeding
// a START/DATA/STOP shifter, with back-to-back frames when data waits.
module uart_tx_ctrl #(
    parameter int BAUD_DIV = 868,
    parameter int FIFO_AW  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [7:0]         wr_data,
    output logic [FIFO_AW:0]   level,
    output logic               full,
    output logic               busy,
    output logic               ovf,
    output logic               uart
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int NUM = 2 ** FIFO_AW;
    localparam logic [CW-1:0] CNT_MAX = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [FIFO_AW:0] DEPTH = (FIFO_AW + 1)'(NUM);
    localparam logic [FIFO_AW:0] LVL_ONE = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state;
    logic [7:0]           mem [NUM];
    logic [FIFO_AW-1:0]   wr_ptr;
    logic [FIFO_AW-1:0]   rd_ptr;
    logic [FIFO_AW:0]     level_next;
    logic [CW-1:0]        cnt;
    logic [2:0]           idx;
    logic [7:0]           shift;
    logic                 push;
    logic                 pop;
    logic                 cnt_end;

    assign cnt_end = (cnt == CNT_MAX);
    assign push    = wr_en && !full;
    // Head is taken on leaving IDLE or at the end of a stop bit.
    assign pop     = (level != '0) &&
                     (state == IDLE || (state == STOP && cnt_end));
    assign busy    = (level != '0) || (state != IDLE);

    always_comb begin
        level_next = level;
        case ({push, pop})
            2'b10:   level_next = level + LVL_ONE;
            2'b01:   level_next = level - LVL_ONE;
            default: level_next = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            level <= level_next;
            full  <= (level_next == DEPTH);
            if (wr_en && full)
                ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
            uart  <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt  <= '0;
                    uart <= 1'b1;
                    if (pop) begin
                        shift <= mem[rd_ptr];
                        state <= START;
                        uart  <= 1'b0;
                    end
                end
                START: begin
                    if (cnt_end) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= DATA;
                        uart  <= shift[0];
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                DATA: begin
                    if (cnt_end) begin
                        cnt   <= '0;
                        shift <= shift >> 1;
                        if (idx == 3'd7) begin
                            state <= STOP;
                            uart  <= 1'b1;
                        end else begin
                            idx  <= idx + 3'd1;
                            uart <= shift[1];
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                STOP: begin
                    if (cnt_end) begin
                        cnt <= '0;
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            state <= START;
                            uart  <= 1'b0;
                        end else begin
                            state <= IDLE;
                            uart  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
